// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the memory-access stage.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_access_stage_pkg;

    localparam int WORD_W     = 32;
    localparam int DMEM_DEPTH = 1024;

    // Stage control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Operation class of a latched request
    typedef enum logic [1:0] {
        OP_PASS  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } op_e;

    // True when a word address falls inside a memory of 'depth' words
    function automatic logic addr_in_range(input logic [WORD_W-1:0] addr, input int depth);
        return addr < WORD_W'(depth);
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Request, data-memory and writeback signal bundle for the memory-access stage.
// Latency: n/a (wiring only).
// Backpressure: req_ready / wb_ready valid-ready pairs carried here.
interface mem_access_if #(
    parameter int TAGW = 6
);
    import mem_access_stage_pkg::*;

    // Execute -> stage request
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_read;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_data;
    logic [TAGW-1:0]   req_tag;
    logic              req_regwrite;

    // Stage <-> data memory
    logic              mem_write;
    logic              mem_read;
    logic [WORD_W-1:0] mem_daddress;
    logic [WORD_W-1:0] mem_din;
    logic [WORD_W-1:0] mem_dout;

    // Stage -> writeback result
    logic              wb_valid;
    logic              wb_ready;
    logic [WORD_W-1:0] wb_data;
    logic [TAGW-1:0]   wb_tag;
    logic              wb_regwrite;
    logic              wb_err;

    // Environment side: execute, data memory and writeback
    modport master (
        output req_valid, req_write, req_read, req_addr, req_data, req_tag, req_regwrite,
        input  req_ready,
        input  mem_write, mem_read, mem_daddress, mem_din,
        output mem_dout,
        input  wb_valid, wb_data, wb_tag, wb_regwrite, wb_err,
        output wb_ready
    );

    // Stage side
    modport slave (
        input  req_valid, req_write, req_read, req_addr, req_data, req_tag, req_regwrite,
        output req_ready,
        output mem_write, mem_read, mem_daddress, mem_din,
        input  mem_dout,
        output wb_valid, wb_data, wb_tag, wb_regwrite, wb_err,
        input  wb_ready
    );

endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: issues one-cycle data-memory strobes and returns one registered result per request.
// Latency: result valid on the second posedge after accept; one op per 2 cycles back-to-back.
// Backpressure: result held stable while wb_ready is low; req_ready only in IDLE or when RESP is draining.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int TAGW  = 6
) (
    input  logic         clock,
    input  logic         reset,
    mem_access_if.slave  bus
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic              err_q, err_d;
    logic [TAGW-1:0]   tag_q, tag_d;
    logic              regwrite_q, regwrite_d;

    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic [WORD_W-1:0] mem_daddress_q, mem_daddress_d;
    logic [WORD_W-1:0] mem_din_q, mem_din_d;

    logic              wb_valid_q, wb_valid_d;
    logic [WORD_W-1:0] wb_data_q, wb_data_d;
    logic [TAGW-1:0]   wb_tag_q, wb_tag_d;
    logic              wb_regwrite_q, wb_regwrite_d;
    logic              wb_err_q, wb_err_d;

    logic              req_ready;
    logic              accept;
    logic              in_range;
    logic              mem_op;

    // Same acceptance rule whether idle or handing off the previous result
    assign req_ready = (state_q == IDLE) | ((state_q == RESP) & bus.wb_ready);
    assign accept    = bus.req_valid & req_ready;
    assign in_range  = addr_in_range(bus.req_addr, DEPTH);
    assign mem_op    = bus.req_read | bus.req_write;

    // Next-state and next-output computation; strobes default low so they last one cycle
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        err_d          = err_q;
        tag_d          = tag_q;
        regwrite_d     = regwrite_q;
        mem_write_d    = 1'b0;
        mem_read_d     = 1'b0;
        mem_daddress_d = mem_daddress_q;
        mem_din_d      = mem_din_q;
        wb_valid_d     = wb_valid_q;
        wb_data_d      = wb_data_q;
        wb_tag_d       = wb_tag_q;
        wb_regwrite_d  = wb_regwrite_q;
        wb_err_d       = wb_err_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            ACCESS: begin
                // Memory output registered on the intervening negedge is valid now
                case (op_q)
                    OP_LOAD: wb_data_d = err_q ? '0 : bus.mem_dout;
                    OP_PASS: wb_data_d = mem_din_q;
                    default: wb_data_d = '0;
                endcase
                wb_valid_d    = 1'b1;
                wb_err_d      = err_q;
                wb_tag_d      = tag_q;
                wb_regwrite_d = regwrite_q & (op_q != OP_STORE) & ~err_q;
                state_d       = RESP;
            end
            RESP: begin
                if (bus.wb_ready) begin
                    wb_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept overrides the RESP exit so a new op can start on the hand-off edge
        if (accept) begin
            tag_d          = bus.req_tag;
            regwrite_d     = bus.req_regwrite;
            mem_daddress_d = bus.req_addr;
            mem_din_d      = bus.req_data;
            err_d          = mem_op & ~in_range;
            if (bus.req_write) begin
                op_d = OP_STORE;
            end else if (bus.req_read) begin
                op_d = OP_LOAD;
            end else begin
                op_d = OP_PASS;
            end
            // Out-of-range addresses never reach the memory
            mem_write_d = bus.req_write & in_range;
            mem_read_d  = ~bus.req_write & bus.req_read & in_range;
            state_d     = ACCESS;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            op_q           <= OP_PASS;
            err_q          <= 1'b0;
            tag_q          <= '0;
            regwrite_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_daddress_q <= '0;
            mem_din_q      <= '0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
            wb_tag_q       <= '0;
            wb_regwrite_q  <= 1'b0;
            wb_err_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            err_q          <= err_d;
            tag_q          <= tag_d;
            regwrite_q     <= regwrite_d;
            mem_write_q    <= mem_write_d;
            mem_read_q     <= mem_read_d;
            mem_daddress_q <= mem_daddress_d;
            mem_din_q      <= mem_din_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_tag_q       <= wb_tag_d;
            wb_regwrite_q  <= wb_regwrite_d;
            wb_err_q       <= wb_err_d;
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.mem_write    = mem_write_q;
    assign bus.mem_read     = mem_read_q;
    assign bus.mem_daddress = mem_daddress_q;
    assign bus.mem_din      = mem_din_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_tag       = wb_tag_q;
    assign bus.wb_regwrite  = wb_regwrite_q;
    assign bus.wb_err       = wb_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a negedge-registered data memory as the downstream load.
// Latency: n/a.
// Backpressure: writeback readiness is driven directly by the steps below.
module tb_mem_access_stage;

    logic clock;
    logic reset;
    int   vectors = 0;
    int   fails   = 0;

    mem_access_if #(.TAGW(6)) bus ();

    mem_access_stage #(.DEPTH(1024), .TAGW(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory: writes and read data registered on the falling edge
    logic [31:0] dmem [1024];
    bit          dmem_init = 1'b0;
    always @(negedge clock) begin
        if (!dmem_init) begin
            for (int i = 0; i < 1024; i++) begin
                dmem[i] <= 32'h5A00_0000 | 32'(i);
            end
            dmem_init <= 1'b1;
        end else begin
            if (bus.mem_write) dmem[bus.mem_daddress[9:0]] <= bus.mem_din;
            if (bus.mem_read)  bus.mem_dout <= dmem[bus.mem_daddress[9:0]];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request for one accepting edge, then withdraw it
    task automatic issue(input logic w, input logic r, input logic [31:0] addr,
                         input logic [31:0] data, input logic [5:0] tag, input logic rw);
        bus.req_write    = w;
        bus.req_read     = r;
        bus.req_addr     = addr;
        bus.req_data     = data;
        bus.req_tag      = tag;
        bus.req_regwrite = rw;
        bus.req_valid    = 1'b1;
        tick();
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_read     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_read     = 1'b0;
        bus.req_addr     = '0;
        bus.req_data     = '0;
        bus.req_tag      = '0;
        bus.req_regwrite = 1'b0;
        bus.wb_ready     = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_mem_read",  32'(bus.mem_read),  32'd0);
        chk("rst_wb_valid",  32'(bus.wb_valid),  32'd0);
        chk("rst_wb_err",    32'(bus.wb_err),    32'd0);
        chk("rst_wb_rw",     32'(bus.wb_regwrite), 32'd0);
        chk("rst_daddr",     bus.mem_daddress,   32'd0);
        chk("rst_din",       bus.mem_din,        32'd0);
        chk("rst_wb_data",   bus.wb_data,        32'd0);
        chk("rst_wb_tag",    32'(bus.wb_tag),    32'd0);
        reset = 1'b0;
        tick();
        chk("idle_ready",    32'(bus.req_ready), 32'd1);

        // Store addr 5
        issue(1'b1, 1'b0, 32'd5, 32'hDEADBEEF, 6'd3, 1'b1);
        chk("st_mem_write",  32'(bus.mem_write), 32'd1);
        chk("st_mem_read",   32'(bus.mem_read),  32'd0);
        chk("st_daddr",      bus.mem_daddress,   32'd5);
        chk("st_din",        bus.mem_din,        32'hDEADBEEF);
        chk("st_wbv_early",  32'(bus.wb_valid),  32'd0);
        chk("st_ready_acc",  32'(bus.req_ready), 32'd0);
        tick();
        chk("st_strobe_1cy", 32'(bus.mem_write), 32'd0);
        chk("st_wb_valid",   32'(bus.wb_valid),  32'd1);
        chk("st_wb_rw",      32'(bus.wb_regwrite), 32'd0);
        chk("st_wb_data",    bus.wb_data,        32'd0);
        chk("st_wb_tag",     32'(bus.wb_tag),    32'd3);
        tick();
        chk("st_wb_drop",    32'(bus.wb_valid),  32'd0);

        // Load addr 5
        issue(1'b0, 1'b1, 32'd5, 32'd0, 6'd4, 1'b1);
        chk("ld_mem_read",   32'(bus.mem_read),  32'd1);
        chk("ld_mem_write",  32'(bus.mem_write), 32'd0);
        chk("ld_wbv_early",  32'(bus.wb_valid),  32'd0);
        tick();
        chk("ld_rd_1cy",     32'(bus.mem_read),  32'd0);
        chk("ld_wb_valid",   32'(bus.wb_valid),  32'd1);
        chk("ld_wb_data",    bus.wb_data,        32'hDEADBEEF);
        chk("ld_wb_rw",      32'(bus.wb_regwrite), 32'd1);
        chk("ld_wb_tag",     32'(bus.wb_tag),    32'd4);
        tick();

        // Pass-through
        issue(1'b0, 1'b0, 32'd64, 32'h12345678, 6'd7, 1'b1);
        chk("pt_mem_write",  32'(bus.mem_write), 32'd0);
        chk("pt_mem_read",   32'(bus.mem_read),  32'd0);
        tick();
        chk("pt_wb_data",    bus.wb_data,        32'h12345678);
        chk("pt_wb_tag",     32'(bus.wb_tag),    32'd7);
        chk("pt_wb_rw",      32'(bus.wb_regwrite), 32'd1);
        chk("pt_wb_err",     32'(bus.wb_err),    32'd0);
        tick();

        // Out-of-range load
        issue(1'b0, 1'b1, 32'd1024, 32'd0, 6'd1, 1'b1);
        chk("oor_ld_read",   32'(bus.mem_read),  32'd0);
        tick();
        chk("oor_ld_valid",  32'(bus.wb_valid),  32'd1);
        chk("oor_ld_err",    32'(bus.wb_err),    32'd1);
        chk("oor_ld_data",   bus.wb_data,        32'd0);
        chk("oor_ld_rw",     32'(bus.wb_regwrite), 32'd0);
        tick();

        // Out-of-range store
        issue(1'b1, 1'b0, 32'hFFFFFFFF, 32'h11111111, 6'd2, 1'b1);
        chk("oor_st_write",  32'(bus.mem_write), 32'd0);
        tick();
        chk("oor_st_err",    32'(bus.wb_err),    32'd1);
        chk("oor_st_rw",     32'(bus.wb_regwrite), 32'd0);
        tick();

        // Top word keeps its initial contents
        issue(1'b0, 1'b1, 32'd1023, 32'd0, 6'd5, 1'b1);
        tick();
        chk("ld1023_data",   bus.wb_data,        32'h5A0003FF);
        chk("ld1023_err",    32'(bus.wb_err),    32'd0);
        tick();

        // Backpressure on a load of addr 3
        bus.wb_ready = 1'b0;
        issue(1'b0, 1'b1, 32'd3, 32'd0, 6'd9, 1'b1);
        tick();
        bus.req_write    = 1'b0;
        bus.req_read     = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_data     = 32'hCAFEF00D;
        bus.req_tag      = 6'd10;
        bus.req_regwrite = 1'b1;
        bus.req_valid    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_wb_valid", 32'(bus.wb_valid),  32'd1);
            chk("bp_wb_data",  bus.wb_data,        32'h5A000003);
            chk("bp_wb_tag",   32'(bus.wb_tag),    32'd9);
            chk("bp_ready",    32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.wb_ready = 1'b1;
        #1;
        chk("bp_ready_rise", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        chk("bp_wb_drop",    32'(bus.wb_valid),  32'd0);
        chk("bp_accepted",   32'(bus.req_ready), 32'd0);
        tick();
        chk("bp_next_data",  bus.wb_data,        32'hCAFEF00D);
        chk("bp_next_tag",   32'(bus.wb_tag),    32'd10);
        tick();

        // Read and write together: write wins
        issue(1'b1, 1'b1, 32'd9, 32'hA5A5A5A5, 6'd11, 1'b1);
        chk("rw_mem_write",  32'(bus.mem_write), 32'd1);
        chk("rw_mem_read",   32'(bus.mem_read),  32'd0);
        tick();
        chk("rw_wb_rw",      32'(bus.wb_regwrite), 32'd0);
        tick();
        issue(1'b0, 1'b1, 32'd9, 32'd0, 6'd12, 1'b1);
        tick();
        chk("rw_ld_data",    bus.wb_data,        32'hA5A5A5A5);
        tick();

        // Reset while in ACCESS after a store accept
        issue(1'b1, 1'b0, 32'd12, 32'h77777777, 6'd13, 1'b1);
        reset = 1'b1;
        tick();
        chk("mr_mem_write",  32'(bus.mem_write), 32'd0);
        chk("mr_wb_valid",   32'(bus.wb_valid),  32'd0);
        chk("mr_daddr",      bus.mem_daddress,   32'd0);
        chk("mr_din",        bus.mem_din,        32'd0);
        chk("mr_idle",       32'(bus.req_ready), 32'd1);
        reset = 1'b0;
        tick();
        chk("mr_no_wb",      32'(bus.wb_valid),  32'd0);
        issue(1'b0, 1'b1, 32'd5, 32'd0, 6'd14, 1'b1);
        chk("mr_ld_read",    32'(bus.mem_read),  32'd1);
        tick();
        chk("mr_ld_valid",   32'(bus.wb_valid),  32'd1);
        chk("mr_ld_data",    bus.wb_data,        32'hDEADBEEF);
        chk("mr_ld_tag",     32'(bus.wb_tag),    32'd14);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
